ltc2601_rx: RTL and testbench

LTC2601_RX -- requirements
Module: ltc2601_rx

---
 rtl/ltc2601_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/ltc2601_rx.sv | 110 +++++++++++
 tb/tb_ltc2601_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ltc2601_pkg.sv
// Shared constants and state encoding for the LTC2601 daisy-chain frame receiver.
package ltc2601_pkg;
  localparam int NUM_CH = 4;
  localparam int WORD_BITS = 24;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [6:0] BIT_COUNT_MAX = 7'd127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by one edge-detect register; level and edges are time-aligned.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clkin,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  // s3 carries the same sample that produced rise/fall, so data stays aligned with the sclk edge
  assign level = s3;
endmodule

// File: rtl/ltc2601_rx.sv
// Receives chip-select framed daisy-chained DAC words and latches them into a per-channel register file.
// state | meaning
// IDLE  | waiting for csel falling edge; sclk ignored
// SHIFT | capturing mosi on each sclk rising edge until csel rises
// CHECK | one cycle: commit frame if bit count exact, else flag error
module ltc2601_rx #(
  parameter int NUM_CH    = ltc2601_pkg::NUM_CH,
  parameter int WORD_BITS = ltc2601_pkg::WORD_BITS
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 csel,
  input  logic                 mosi,
  input  logic [1:0]           rd_addr,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [6:0]           bit_count
);
  import ltc2601_pkg::*;

  localparam int TOTAL = NUM_CH * WORD_BITS;
  localparam logic [6:0] FRAME_BITS = 7'(TOTAL);

  rx_state_e state, state_nxt;
  logic [TOTAL-1:0] shreg;
  logic [NUM_CH-1:0][WORD_BITS-1:0] regs;
  logic fall_pend;
  logic start;

  logic sclk_rise, cs_rise, cs_fall, mosi_lvl;
  logic sclk_lvl_unused, sclk_fall_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clkin(clkin), .reset(reset), .din(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csel (
    .clkin(clkin), .reset(reset), .din(csel),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clkin(clkin), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall || fall_pend) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = IDLE;
        if (bit_count == FRAME_BITS) frame_done = 1'b1;
        else                         frame_err  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_count <= '0;
      fall_pend <= 1'b0;
      regs      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          fall_pend <= 1'b0;
          if (start) begin
            shreg     <= '0;
            bit_count <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg <= {shreg[TOTAL-2:0], mosi_lvl};
            if (bit_count != BIT_COUNT_MAX) bit_count <= bit_count + 7'd1;
          end
        end
        CHECK: begin
          // a new frame may start while we are still checking the last one
          fall_pend <= cs_fall;
          if (frame_done) regs <= shreg;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign rd_data = regs[rd_addr];
endmodule

// File: tb/tb_ltc2601_rx.sv
// Scoreboard bench for ltc2601_rx: stimulus queues expected frame outcomes, a monitor checks each pulse.
module tb_ltc2601_rx;
  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        csel = 1'b1;
  logic        mosi = 1'b0;
  logic [1:0]  rd_addr;
  logic [23:0] rd_data;
  logic        busy, frame_done, frame_err;
  logic [6:0]  bit_count;

  ltc2601_rx dut (
    .clkin(clkin), .reset(reset), .sclk(sclk), .csel(csel), .mosi(mosi),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .bit_count(bit_count)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit               done;
    int               bits;
    logic [3:0][23:0] regs;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0][23:0] model;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit done, input int bits);
    exp_t e;
    e.done = done;
    e.bits = bits;
    e.regs = model;
    exp_q.push_back(e);
  endtask

  // Sends bits v[n-1] first; abort_at >= 0 asserts reset before that bit is sent.
  task automatic send_bits(input logic [159:0] v, input int n, input int gap, input int abort_at);
    csel = 1'b0;
    repeat (4) @(negedge clkin);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        csel  = 1'b1;
        sclk  = 1'b0;
        return;
      end
      mosi = v[n-1-i];
      sclk = 1'b0;
      repeat (2) @(negedge clkin);
      sclk = 1'b1;
      repeat (2) @(negedge clkin);
    end
    sclk = 1'b0;
    repeat (2) @(negedge clkin);
    csel = 1'b1;
    repeat (gap) @(negedge clkin);
  endtask

  task automatic send_valid(input logic [23:0] w3, input logic [23:0] w2,
                            input logic [23:0] w1, input logic [23:0] w0, input int gap);
    model[3] = w3;
    model[2] = w2;
    model[1] = w1;
    model[0] = w0;
    push_exp(1'b1, 96);
    send_bits({64'h0, w3, w2, w1, w0}, 96, gap, -1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clkin);
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clkin);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    rd_addr = 2'd0;
    forever begin
      @(negedge clkin);
      if (!reset && (frame_done || frame_err)) begin
        chk("pulse_exclusive", 32'(frame_done & frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse done=%0d err=%0d expected no pulse", frame_done, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_done", 32'(frame_done), 32'(e.done));
          chk("bit_count_at_check", 32'(bit_count), 32'(e.bits));
          @(posedge clkin);
          #1;
          for (int ch = 0; ch < 4; ch++) begin
            rd_addr = 2'(ch);
            #1;
            chk($sformatf("rd_data_ch%0d", ch), 32'(rd_data), 32'(e.regs[ch]));
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [159:0] v;
    model = '0;
    repeat (3) @(negedge clkin);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bit_count", 32'(bit_count), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clkin);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // valid 96-bit frame
    send_valid(24'h30F080, 24'h301234, 24'h30ABCD, 24'h300000, 6);
    wait_idle();

    // truncated, over-long and saturating frames
    v = {64'h0, 24'h30F080, 24'h301234, 24'h30ABCD, 24'h300000};
    push_exp(1'b0, 95);
    send_bits(v, 95, 6, -1);
    wait_idle();
    push_exp(1'b0, 100);
    send_bits({32'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5}, 100, 6, -1);
    wait_idle();
    push_exp(1'b0, 127);
    send_bits({32'h0, 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0}, 130, 6, -1);
    wait_idle();

    // reset in the middle of a frame
    send_bits({64'h0, 96'h311111_322222_333333_344444}, 96, 6, 40);
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_bit_count", 32'(bit_count), 32'd0);
    chk("midreset_done", 32'(frame_done), 32'd0);
    chk("midreset_err", 32'(frame_err), 32'd0);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    model = '0;
    repeat (4) @(negedge clkin);
    reset = 1'b0;
    repeat (6) @(negedge clkin);
    send_valid(24'h3A0001, 24'h3B0002, 24'h3C0003, 24'h3D0004, 6);
    wait_idle();

    // sclk activity with csel high must not capture anything
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b1;
      repeat (2) @(negedge clkin);
      sclk = 1'b0;
      repeat (2) @(negedge clkin);
    end
    chk("idle_sclk_busy", 32'(busy), 32'd0);
    chk("idle_sclk_bit_count", 32'(bit_count), 32'd96);

    // back-to-back frames with short csel-high gaps
    send_valid(24'h301111, 24'h302222, 24'h303333, 24'h304444, 4);
    send_valid(24'h30AAAA, 24'h30BBBB, 24'h30CCCC, 24'h30DDDD, 1);
    send_valid(24'h3F0F0F, 24'h3E1E1E, 24'h3D2D2D, 24'h3C3C3C, 6);
    wait_idle();

    // random data at sclk = clkin/4
    for (int f = 0; f < 50; f++) begin
      send_valid(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
                 int'($urandom_range(6, 1)));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
